regs_wb_scheduler: RTL and testbench

//  Owns the register file's single write port and tracks pending writes (scoreboard).

---
 rtl/regs_ctrl_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/regs_wb_scheduler.sv | 90 +++++++++
 tb/tb_regs_wb_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_ctrl_pkg.sv
// Shared constants and types for the register-file control path.
package regs_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan at rr_ptr; the pointer
// moves to the slot after the winner and holds when nobody requests.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/regs_wb_scheduler.sv
// Owns the register-file write port: arbitrates writeback sources, registers the
// winning write, tracks pending destinations and flags RAW/WAW hazards.
module regs_wb_scheduler
  import regs_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = regs_ctrl_pkg::XLEN,
  parameter int AW   = regs_ctrl_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        issue_rs1,
  input  logic [AW-1:0]        issue_rs2,
  output logic                 hazard,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        Wt_addr,
  output logic [XLEN-1:0]      Wt_data,
  output logic                 RegWrite,
  output logic [NREG-1:0]      busy,
  output logic                 err
);
  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            hs;
  logic            wb_orphan;
  logic [NREG-1:0] busy_next;

  // Requests are masked during reset so nothing is granted and the pointer stays put.
  assign req_eff = rst ? '0 : req_valid;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_eff),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign hazard = ((issue_rs1 != '0) && busy[issue_rs1]) ||
                  ((issue_rs2 != '0) && busy[issue_rs2]) ||
                  ((issue_rd  != '0) && busy[issue_rd]);

  assign wb_orphan = hs && (sel_addr != '0) && !busy[sel_addr];

  // Set is applied after clear so a new producer keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (RegWrite && (Wt_addr != '0)) busy_next[Wt_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite <= 1'b0;
      Wt_addr  <= '0;
      Wt_data  <= '0;
      busy     <= '0;
      err      <= 1'b0;
    end else begin
      RegWrite <= hs && (sel_addr != '0);
      if (hs) begin
        Wt_addr <= sel_addr;
        Wt_data <= sel_data;
      end
      busy <= busy_next;
      if (wb_orphan || (issue_valid && hazard)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regs_wb_scheduler.sv
// Directed bench for regs_wb_scheduler with a writeback scoreboard and register-file model.
module tb_regs_wb_scheduler;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        issue_rs1;
  logic [AW-1:0]        issue_rs2;
  logic                 hazard;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        Wt_addr;
  logic [XLEN-1:0]      Wt_data;
  logic                 RegWrite;
  logic [31:0]          busy;
  logic                 err;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t             exp_q[$];
  logic [XLEN-1:0] rf [32];
  logic [AW-1:0]   cur_addr [NREQ];
  logic [XLEN-1:0] cur_data [NREQ];
  int              n_checks = 0;
  int              n_fail   = 0;

  regs_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .hazard      (hazard),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .Wt_addr     (Wt_addr),
    .Wt_data     (Wt_data),
    .RegWrite    (RegWrite),
    .busy        (busy),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file as seen by the write port
  always @(posedge clk) begin
    if (RegWrite === 1'b1 && Wt_addr != '0) rf[Wt_addr] <= Wt_data;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int src, input logic v, input logic [AW-1:0] a,
                                input logic [XLEN-1:0] d);
    req_valid[src]          = v;
    req_addr[src*AW +: AW]  = a;
    req_data[src*XLEN +: XLEN] = d;
    cur_addr[src] = a;
    cur_data[src] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every register-file write must match the oldest expected writeback
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("wb_unexpected", 64'(RegWrite), 64'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check_output("wb_addr", 64'(Wt_addr), 64'(e.addr));
        check_output("wb_data", 64'(Wt_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    for (int s = 0; s < NREQ; s++) apply_stimulus(s, 1'b1, AW'(s + 1), 32'h1000 + s);

    $display("[TB] reset with all sources requesting");
    for (int c = 0; c < 2; c++) begin
      tick();
      check_output("rst_ready", 64'(req_ready), 64'd0);
      check_output("rst_regwrite", 64'(RegWrite), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_err", 64'(err), 64'd0);
    end

    $display("[TB] issue x5 then writeback from source 0");
    rst = 1'b0;
    for (int s = 0; s < NREQ; s++) apply_stimulus(s, 1'b0, '0, '0);
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    #1 check_output("x5_issue_hazard", 64'(hazard), 64'd0);
    tick();
    issue_valid = 1'b0;
    issue_rd = '0;
    check_output("x5_busy_set", 64'(busy), 64'h20);
    apply_stimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check_output("x5_ready", 64'(req_ready), 64'b001);
    exp_q.push_back('{cur_addr[0], cur_data[0]});
    tick();
    apply_stimulus(0, 1'b0, '0, '0);
    check_output("x5_regwrite", 64'(RegWrite), 64'd1);
    check_output("x5_busy_held", 64'(busy[5]), 64'd1);
    tick();
    check_output("x5_busy_clr", 64'(busy[5]), 64'd0);
    check_output("x5_regwrite_off", 64'(RegWrite), 64'd0);
    check_output("x5_rf", 64'(rf[5]), 64'hDEADBEEF);
    check_output("x5_err", 64'(err), 64'd0);

    $display("[TB] round-robin with all sources busy");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rr_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'b1;
      issue_rd = AW'(10 + i);
      tick();
    end
    issue_valid = 1'b0;
    issue_rd = '0;
    check_output("rr_busy_set", 64'(busy), 64'h0000_FC00);
    for (int s = 0; s < NREQ; s++) apply_stimulus(s, 1'b1, AW'(10 + s), 32'hA000_0000 + s);
    for (int k = 0; k < 6; k++) begin
      int g;
      g = k % 3;
      #1 check_output($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(3'b001 << g));
      exp_q.push_back('{cur_addr[g], cur_data[g]});
      tick();
      if (k < 3) apply_stimulus(g, 1'b1, AW'(13 + g), 32'hB000_0000 + g);
      else       apply_stimulus(g, 1'b0, '0, '0);
    end
    tick();
    tick();
    check_output("rr_busy_clr", 64'(busy), 64'd0);
    check_output("rr_err", 64'(err), 64'd0);
    check_output("rr_rf15", 64'(rf[15]), 64'hB000_0002);

    $display("[TB] hazard detection on x7");
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_rs1 = 5'd7;
    #1 check_output("raw_rs1", 64'(hazard), 64'd1);
    issue_rs1 = 5'd0;
    #1 check_output("rs1_x0", 64'(hazard), 64'd0);
    issue_rd = 5'd7;
    #1 check_output("waw_rd", 64'(hazard), 64'd1);
    issue_rd = 5'd0;
    issue_rs2 = 5'd7;
    #1 check_output("raw_rs2", 64'(hazard), 64'd1);
    issue_rs2 = 5'd0;
    apply_stimulus(1, 1'b1, 5'd7, 32'h0000_0077);
    #1 check_output("x7_ready", 64'(req_ready), 64'b010);
    exp_q.push_back('{cur_addr[1], cur_data[1]});
    tick();
    apply_stimulus(1, 1'b0, '0, '0);
    issue_rd = 5'd7;
    #1 check_output("x7_no_forward", 64'(hazard), 64'd1);
    tick();
    check_output("x7_hazard_clr", 64'(hazard), 64'd0);
    check_output("x7_busy_clr", 64'(busy[7]), 64'd0);
    issue_rd = '0;

    $display("[TB] same-edge clear and set on x9");
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    issue_rd = '0;
    apply_stimulus(2, 1'b1, 5'd9, 32'h0000_0099);
    #1 check_output("x9_ready", 64'(req_ready), 64'b100);
    exp_q.push_back('{cur_addr[2], cur_data[2]});
    tick();
    apply_stimulus(2, 1'b0, '0, '0);
    check_output("x9_wb_err", 64'(err), 64'd0);
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    issue_rd = '0;
    check_output("x9_busy_kept", 64'(busy[9]), 64'd1);
    check_output("x9_rf", 64'(rf[9]), 64'h99);
    check_output("x9_issue_on_hazard_err", 64'(err), 64'd1);

    $display("[TB] orphan writeback and x0 writeback");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst2_err", 64'(err), 64'd0);
    apply_stimulus(0, 1'b1, 5'd3, 32'h0000_3333);
    #1 check_output("x3_ready", 64'(req_ready), 64'b001);
    exp_q.push_back('{cur_addr[0], cur_data[0]});
    tick();
    apply_stimulus(0, 1'b0, '0, '0);
    check_output("x3_err", 64'(err), 64'd1);
    check_output("x3_regwrite", 64'(RegWrite), 64'd1);
    apply_stimulus(1, 1'b1, 5'd0, 32'h0000_0F0F);
    #1 check_output("x0_ready", 64'(req_ready), 64'b010);
    tick();
    check_output("x0_regwrite", 64'(RegWrite), 64'd0);
    check_output("x3_rf", 64'(rf[3]), 64'h3333);
    apply_stimulus(0, 1'b1, 5'd0, 32'h0000_0A0A);
    apply_stimulus(1, 1'b1, 5'd0, 32'h0000_0B0B);
    #1 check_output("x0_ptr_advanced", 64'(req_ready), 64'b001);
    tick();
    apply_stimulus(0, 1'b0, '0, '0);
    apply_stimulus(1, 1'b0, '0, '0);
    check_output("x0_regwrite2", 64'(RegWrite), 64'd0);
    tick();
    check_output("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
